// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 10;

   // Bit positions of the two requesters in the request/grant vectors.
   localparam int unsigned REQ_I = 0;
   localparam int unsigned REQ_D = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

   // Converts a one-hot grant vector into the requester id it selects.
   function automatic grant_e grant_to_id(input logic [1:0] grant);
      return grant[REQ_D] ? GRANT_D : GRANT_I;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and RAM-side signals of the arbiter.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

   // Instruction-fetch requester
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_ack;
   logic [DATA_WIDTH-1:0] i_rdata;

   // Load/store requester
   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic                  d_ack;
   logic [DATA_WIDTH-1:0] d_rdata;

   // RAM side
   logic                  ram_cs;
   logic                  ram_we;
   logic                  ram_oe;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Status
   logic                  busy;

   // Arbiter view
   modport slave (
      input  i_req, i_addr,
      output i_ack, i_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ack, d_rdata,
      output ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
      input  ram_rdata,
      output busy
   );

   // Requesters plus RAM view
   modport master (
      output i_req, i_addr,
      input  i_ack, i_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ack, d_rdata,
      input  ram_cs, ram_we, ram_oe, ram_addr, ram_wdata,
      output ram_rdata,
      input  busy
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: request vector plus last served port in, one-hot grant out.
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  grant_e     last_grant,
   output logic [1:0] grant
);

   // A lone requester wins; on a tie the port that was not served last wins.
   always_comb begin
      grant = '0;
      case (req)
         2'b01:   grant[REQ_I] = 1'b1;
         2'b10:   grant[REQ_D] = 1'b1;
         2'b11: begin
            if (last_grant == GRANT_I) begin
               grant[REQ_D] = 1'b1;
            end else begin
               grant[REQ_I] = 1'b1;
            end
         end
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (I) and
// load/store (D). Per transaction it sequences cs/we/oe/address, returns a
// one-cycle ack to the winner and arbitrates round-robin between the ports.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   // Sequencer and arbitration state
   state_e                state_q, state_d;
   grant_e                last_grant_q, last_grant_d;

   // Transaction captured in IDLE; requester inputs are ignored afterwards
   grant_e                cur_id_q, cur_id_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic                  cur_we_q, cur_we_d;
   logic [DATA_WIDTH-1:0] cur_wdata_q, cur_wdata_d;

   // Registered outputs
   logic                  i_ack_q, i_ack_d;
   logic                  d_ack_q, d_ack_d;
   logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  ram_cs_q, ram_cs_d;
   logic                  ram_we_q, ram_we_d;
   logic                  ram_oe_q, ram_oe_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic                  busy_q, busy_d;

   logic [1:0]            req_vec;
   logic [1:0]            grant;
   grant_e                win_id;
   logic                  win_we;

   assign req_vec[REQ_I] = bus.i_req;
   assign req_vec[REQ_D] = bus.d_req;

   rr_arb2 u_rr_arb2 (
      .req        (req_vec),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   assign win_id = grant_to_id(grant);
   assign win_we = (win_id == GRANT_D) && bus.d_we;

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cur_id_d     = cur_id_q;
      cur_addr_d   = cur_addr_q;
      cur_we_d     = cur_we_q;
      cur_wdata_d  = cur_wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      i_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      ram_cs_d     = 1'b0;
      ram_we_d     = 1'b0;
      ram_oe_d     = 1'b0;
      ram_addr_d   = '0;
      ram_wdata_d  = '0;

      case (state_q)
         ST_IDLE: begin
            if (grant != 2'b00) begin
               cur_id_d     = win_id;
               cur_we_d     = win_we;
               cur_addr_d   = (win_id == GRANT_D) ? bus.d_addr : bus.i_addr;
               cur_wdata_d  = (win_id == GRANT_D) ? bus.d_wdata : '0;
               last_grant_d = win_id;
               state_d      = ST_ISSUE;
               // Drive the RAM for ISSUE straight from the sampled request.
               ram_cs_d     = 1'b1;
               ram_we_d     = win_we;
               ram_oe_d     = !win_we;
               ram_addr_d   = cur_addr_d;
               ram_wdata_d  = win_we ? bus.d_wdata : '0;
            end
         end

         ST_ISSUE: begin
            if (cur_we_q) begin
               // Write completed at the end of ISSUE: acknowledge next.
               state_d = ST_RESP;
               i_ack_d = (cur_id_q == GRANT_I);
               d_ack_d = (cur_id_q == GRANT_D);
            end else begin
               // Read: keep the RAM selected while its registered output settles.
               state_d    = ST_HOLD;
               ram_cs_d   = 1'b1;
               ram_oe_d   = 1'b1;
               ram_addr_d = cur_addr_q;
            end
         end

         ST_HOLD: begin
            state_d = ST_RESP;
            if (cur_id_q == GRANT_I) begin
               i_rdata_d = bus.ram_rdata;
            end else begin
               d_rdata_d = bus.ram_rdata;
            end
            i_ack_d = (cur_id_q == GRANT_I);
            d_ack_d = (cur_id_q == GRANT_D);
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; async reset abandons any transaction without an ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_D;
         cur_id_q     <= GRANT_I;
         cur_addr_q   <= '0;
         cur_we_q     <= 1'b0;
         cur_wdata_q  <= '0;
         i_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         ram_cs_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_oe_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cur_id_q     <= cur_id_d;
         cur_addr_q   <= cur_addr_d;
         cur_we_q     <= cur_we_d;
         cur_wdata_q  <= cur_wdata_d;
         i_ack_q      <= i_ack_d;
         d_ack_q      <= d_ack_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         ram_cs_q     <= ram_cs_d;
         ram_we_q     <= ram_we_d;
         ram_oe_q     <= ram_oe_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.i_ack     = i_ack_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.ram_cs    = ram_cs_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_oe    = ram_oe_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural RAM, reference model of
// grant order/latency/memory contents, and a monitor that checks every ack and RAM write.
module tb_mem_port_arbiter;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running cycle number, stable when sampled on the falling edge.
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- RAM model: 1-cycle registered read, output gated by cs&oe&!we
   logic [DW-1:0] ram_mem [DEPTH];
   logic [DW-1:0] ram_q = '0;
   logic          ram_init_done = 1'b0;

   function automatic logic [DW-1:0] init_word(input int unsigned a);
      return (a * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
   endfunction

   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
         ram_init_done <= 1'b1;
      end else if (bus.ram_cs) begin
         if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
         else            ram_q <= ram_mem[bus.ram_addr];
      end
   end
   assign bus.ram_rdata = (bus.ram_cs && bus.ram_oe && !bus.ram_we) ? ram_q : '0;

   // ---------------- Reference model and scoreboard
   typedef struct { logic [DW-1:0] data; int unsigned cyc; logic we; } rsp_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int unsigned cyc; } wr_t;

   rsp_t          exp_i[$];
   rsp_t          exp_d[$];
   wr_t           exp_w[$];
   logic [DW-1:0] ref_mem [DEPTH];
   logic          ref_last_d;
   logic [DW-1:0] hold_i, hold_d;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Serve one transaction starting with its IDLE sample cycle; returns the ack cycle.
   function automatic int unsigned model_serve(input logic is_d, input logic we,
                                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                               input int unsigned start);
      rsp_t        r;
      wr_t         w;
      int unsigned ack;
      ack   = start + (we ? 2 : 3);
      r.we  = we;
      r.cyc = ack;
      if (we) begin
         ref_mem[addr] = wdata;
         w.addr = addr;
         w.data = wdata;
         w.cyc  = start + 1;
         exp_w.push_back(w);
         r.data = '0;
      end else begin
         r.data = ref_mem[addr];
      end
      if (is_d) exp_d.push_back(r);
      else      exp_i.push_back(r);
      ref_last_d = is_d;
      return ack;
   endfunction

   function automatic void model_reset();
      ref_last_d = 1'b1;
      hold_i     = '0;
      hold_d     = '0;
      exp_i.delete();
      exp_d.delete();
      exp_w.delete();
   endfunction

   // ---------------- Monitor: compares whatever the DUT presents against the queues
   always @(negedge clk) begin
      rsp_t r;
      wr_t  w;
      if (!rst) begin
         if (bus.i_ack) begin
            if (exp_i.size() == 0) begin
               chk("i_ack_unexpected", 64'(bus.i_ack), 64'd0);
            end else begin
               r = exp_i.pop_front();
               chk("i_rdata", 64'(bus.i_rdata), 64'(r.data));
               chk("i_ack_cycle", 64'(cyc), 64'(r.cyc));
               chk("d_rdata_held_on_i_ack", 64'(bus.d_rdata), 64'(hold_d));
               chk("ack_exclusive", 64'(bus.d_ack), 64'd0);
               hold_i = r.data;
            end
         end
         if (bus.d_ack) begin
            if (exp_d.size() == 0) begin
               chk("d_ack_unexpected", 64'(bus.d_ack), 64'd0);
            end else begin
               r = exp_d.pop_front();
               if (r.we) chk("d_rdata_kept_on_write", 64'(bus.d_rdata), 64'(hold_d));
               else      chk("d_rdata", 64'(bus.d_rdata), 64'(r.data));
               chk("d_ack_cycle", 64'(cyc), 64'(r.cyc));
               chk("i_rdata_held_on_d_ack", 64'(bus.i_rdata), 64'(hold_i));
               if (!r.we) hold_d = r.data;
            end
         end
         if (bus.ram_cs && bus.ram_we) begin
            if (exp_w.size() == 0) begin
               chk("ram_write_unexpected", 64'(bus.ram_we), 64'd0);
            end else begin
               w = exp_w.pop_front();
               chk("ram_waddr", 64'(bus.ram_addr), 64'(w.addr));
               chk("ram_wdata", 64'(bus.ram_wdata), 64'(w.data));
               chk("ram_write_cycle", 64'(cyc), 64'(w.cyc));
               chk("ram_oe_in_write", 64'(bus.ram_oe), 64'd0);
            end
         end
      end
   end

   // ---------------- Stimulus
   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({bus.i_ack, bus.d_ack, bus.ram_cs, bus.ram_we, bus.ram_oe, bus.busy}), 64'd0);
      chk({tag, "_rdata"}, {bus.i_rdata, bus.d_rdata}, 64'd0);
      chk({tag, "_ram_bus"}, 64'({bus.ram_addr, bus.ram_wdata}), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One arbitration round: requests rise together in an IDLE cycle; each drops on its ack.
   task automatic run_round(input logic en_i, input logic [AW-1:0] ia,
                            input logic en_d, input logic dwe, input logic [AW-1:0] da,
                            input logic [DW-1:0] dwd, input logic mess, input int unsigned gap);
      int unsigned start, a0, budget;
      logic        done_i, done_d, drop;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      start       = cyc;
      bus.i_addr  = ia;
      bus.d_addr  = da;
      bus.d_we    = dwe;
      bus.d_wdata = dwd;
      bus.i_req   = en_i;
      bus.d_req   = en_d;
      if (en_i && en_d) begin
         if (ref_last_d) begin
            a0 = model_serve(1'b0, 1'b0, ia, '0, start);
            void'(model_serve(1'b1, dwe, da, dwd, a0 + 1));
         end else begin
            a0 = model_serve(1'b1, dwe, da, dwd, start);
            void'(model_serve(1'b0, 1'b0, ia, '0, a0 + 1));
         end
      end else if (en_i) begin
         void'(model_serve(1'b0, 1'b0, ia, '0, start));
      end else if (en_d) begin
         void'(model_serve(1'b1, dwe, da, dwd, start));
      end
      drop   = 1'($urandom);
      done_i = !en_i;
      done_d = !en_d;
      budget = 0;
      while (!(done_i && done_d) && budget < 30) begin
         @(negedge clk);
         budget++;
         if (mess && !(en_i && en_d) && budget == 1) begin
            bus.i_addr  = AW'($urandom);
            bus.d_addr  = AW'($urandom);
            bus.d_wdata = DW'($urandom);
            bus.d_we    = 1'($urandom);
            if (drop) begin
               bus.i_req = 1'b0;
               bus.d_req = 1'b0;
            end
         end
         if (bus.i_ack) begin bus.i_req = 1'b0; done_i = 1'b1; end
         if (bus.d_ack) begin bus.d_req = 1'b0; done_d = 1'b1; end
      end
      if (!(done_i && done_d)) begin
         chk("round_timeout", 64'({done_i, done_d}), 64'd3);
         do_reset();
      end
   endtask

   // Requests held high across n transactions; each port steps its address after its ack.
   task automatic run_held(input logic en_i, input logic en_d,
                           input logic [AW-1:0] ia0, input logic [AW-1:0] da0, input int unsigned n);
      int unsigned     t, got, budget;
      logic            is_d;
      logic [AW-1:0]   ia, da;
      @(negedge clk);
      t           = cyc;
      bus.i_addr  = ia0;
      bus.d_addr  = da0;
      bus.d_we    = 1'b0;
      bus.i_req   = en_i;
      bus.d_req   = en_d;
      ia = ia0;
      da = da0;
      for (int unsigned k = 0; k < n; k++) begin
         is_d = (en_i && en_d) ? !ref_last_d : en_d;
         t = model_serve(is_d, 1'b0, is_d ? da : ia, '0, t) + 1;
         if (is_d) da = da + AW'(1);
         else      ia = ia + AW'(1);
      end
      got    = 0;
      budget = 0;
      while (got < n && budget < n * 6 + 10) begin
         @(negedge clk);
         budget++;
         if (bus.i_ack) begin got++; bus.i_addr = bus.i_addr + AW'(1); end
         if (bus.d_ack) begin got++; bus.d_addr = bus.d_addr + AW'(1); end
         if (got >= n) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
         end
      end
      if (got < n) begin
         chk("held_timeout", 64'(got), 64'(n));
         do_reset();
      end
   endtask

   // Reset asserted while a fetch sits in HOLD: everything clears at once, no ack follows.
   task automatic reset_mid_read();
      @(negedge clk);
      bus.i_addr = 10'h2AA;
      bus.i_req  = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_outputs_zero("rst_mid_read");
      bus.i_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [1:0] sel;
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;

      // Both ports rise together right after reset: I, D, I, D.
      run_held(1'b1, 1'b1, 10'h100, 10'h200, 4);

      // D write then D read of the same word.
      run_round(1'b0, '0, 1'b1, 1'b1, 10'h0A5, 32'hDEAD_BEEF, 1'b0, 0);
      run_round(1'b0, '0, 1'b1, 1'b0, 10'h0A5, '0, 1'b0, 0);

      // I read of 0x010 wins over a pending D write to 0x020 (last grant was D).
      run_round(1'b0, '0, 1'b1, 1'b1, 10'h010, 32'h1111_1111, 1'b0, 0);
      run_round(1'b1, 10'h010, 1'b1, 1'b1, 10'h020, 32'h2468_ACE0, 1'b0, 0);
      run_round(1'b0, '0, 1'b1, 1'b0, 10'h020, '0, 1'b0, 0);

      // D inputs scrambled during ISSUE; RAM must see the sampled values.
      run_round(1'b0, '0, 1'b1, 1'b1, 10'h155, 32'hCAFE_F00D, 1'b1, 0);
      run_round(1'b0, '0, 1'b1, 1'b0, 10'h155, '0, 1'b1, 1);

      // Four back-to-back fetches across the address wrap.
      run_held(1'b1, 1'b0, 10'h3FF, '0, 4);

      // Reset in HOLD, then a normal fetch from 0x004.
      reset_mid_read();
      run_round(1'b1, 10'h004, 1'b0, 1'b0, '0, '0, 1'b0, 0);

      // Randomised rounds on a small address window so reads hit earlier writes.
      repeat (150) begin
         sel = 2'($urandom_range(1, 3));
         run_round(sel[0], AW'($urandom_range(0, 31)), sel[1], 1'($urandom),
                   AW'($urandom_range(0, 31)), DW'($urandom), 1'($urandom),
                   $urandom_range(0, 2));
      end
      run_held(1'b1, 1'b1, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)), 6);

      repeat (6) @(negedge clk);
      chk("i_queue_drained", 64'(exp_i.size()), 64'd0);
      chk("d_queue_drained", 64'(exp_d.size()), 64'd0);
      chk("w_queue_drained", 64'(exp_w.size()), 64'd0);
      chk("idle_at_end", 64'(bus.busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Hard stop if the run wedges somewhere unexpected.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog expired");
   end

endmodule
